// File: rtl/control_unit.sv
// Fetch/decode/execute sequencer for the 8-bit accumulator processor.
// Drives datapath load/select strobes from the opcode and accumulator flags.
module control_unit (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic [2:0] ir_i,
  input  logic       aeq0_i,
  input  logic       apos_i,
  input  logic       enter_i,
  output logic       ir_load_o,
  output logic       pc_load_o,
  output logic       jmp_mux_o,
  output logic       mem_inst_o,
  output logic       mem_wr_o,
  output logic [1:0] a_sel_o,
  output logic       a_load_o,
  output logic       sub_o,
  output logic       halt_o,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    StStart  = 4'b0000,
    StFetch  = 4'b0001,
    StDecode = 4'b0010,
    StLoad   = 4'b1000,
    StStore  = 4'b1001,
    StAdd    = 4'b1010,
    StSub    = 4'b1011,
    StIn     = 4'b1100,
    StJz     = 4'b1101,
    StJpos   = 4'b1110,
    StHalt   = 4'b1111
  } state_e;

  localparam logic [1:0] ASelAlu = 2'b00;
  localparam logic [1:0] ASelIn  = 2'b01;
  localparam logic [1:0] ASelMem = 2'b10;

  state_e state_q, state_d;
  logic   enter_q;
  logic   enter_edge;

  // enter_q resets high so a button held through reset is not seen as an edge.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= StStart;
      enter_q <= 1'b1;
    end else begin
      state_q <= state_d;
      enter_q <= enter_i;
    end
  end

  assign enter_edge = enter_i & ~enter_q;
  assign state_o    = state_q;

  always_comb begin
    state_d    = state_q;
    ir_load_o  = 1'b0;
    pc_load_o  = 1'b0;
    jmp_mux_o  = 1'b0;
    mem_inst_o = 1'b0;
    mem_wr_o   = 1'b0;
    a_sel_o    = ASelAlu;
    a_load_o   = 1'b0;
    sub_o      = 1'b0;
    halt_o     = 1'b0;

    case (state_q)
      StStart: state_d = StFetch;
      StFetch: begin
        ir_load_o = 1'b1;
        pc_load_o = 1'b1;
        state_d   = StDecode;
      end
      StDecode: begin
        mem_inst_o = 1'b1;
        state_d    = state_e'({1'b1, ir_i});
      end
      StLoad: begin
        mem_inst_o = 1'b1;
        a_sel_o    = ASelMem;
        a_load_o   = 1'b1;
        state_d    = StFetch;
      end
      StStore: begin
        mem_inst_o = 1'b1;
        mem_wr_o   = 1'b1;
        state_d    = StFetch;
      end
      StAdd: begin
        mem_inst_o = 1'b1;
        a_load_o   = 1'b1;
        state_d    = StFetch;
      end
      StSub: begin
        mem_inst_o = 1'b1;
        sub_o      = 1'b1;
        a_load_o   = 1'b1;
        state_d    = StFetch;
      end
      StIn: begin
        a_sel_o  = ASelIn;
        a_load_o = enter_edge;
        if (enter_edge) state_d = StFetch;
      end
      StJz: begin
        jmp_mux_o = 1'b1;
        pc_load_o = aeq0_i;
        state_d   = StFetch;
      end
      StJpos: begin
        jmp_mux_o = 1'b1;
        pc_load_o = apos_i;
        state_d   = StFetch;
      end
      StHalt: begin
        halt_o  = 1'b1;
        state_d = StHalt;
      end
      // Encodings 0011..0111 are never entered; recover through START.
      default: state_d = StStart;
    endcase
  end

endmodule
